magnitude_compare: RTL and testbench
====================================

// Module: magnitude_compare
// PURPOSE
//  Registered unsigned magnitude comparator for the operator/display datapath.
//  Compares two WIDTH-bit operands a and b when enabled.
//  Drives a 5-bit status word that the downstream display decoder consumes:
//  valid, greater, equal, less, not-equal.
// PARAMETERS
//  WIDTH  4  operand width in bits; the result stays 5 bits for any WIDTH
// PORTS
//  clk     in   1      system clock; all state updates on rising edge
//  rst     in   1      synchronous reset, active-high
//  EN      in   1      compare enable, sampled on the rising edge of clk
//  a       in   WIDTH  operand A, unsigned
//  b       in   WIDTH  operand B, unsigned
//  result  out  5      registered status word {valid, gt, eq, lt, ne}
// BEHAVIOUR
//  - Clocking: one clock (clk). Reset (rst) is synchronous and active-high.
//  - Reset: rst=1 at a rising edge -> result=5'b00000 on that edge.
//    rst has priority over EN.
//  - Latency: 1 cycle. Inputs sampled at edge N appear on result after edge N.
//    No combinational path from inputs to result.
//  - Result bit map:
//      [4] valid : 1 when the last sampled EN was 1
//      [3] gt    : a > b, unsigned
//      [2] eq    : a == b
//      [1] lt    : a < b, unsigned
//      [0] ne    : a != b; must equal gt|lt
//  - Compare rules:
//      * Unsigned compare over the full WIDTH bits.
//      * Exactly one of gt/eq/lt is 1 whenever valid=1.
//  - EN=0 at an edge (rst=0): result=5'b00000 on that edge.
//      * Flags are not held. Downstream logic treats valid=0 as a blank display.
//  - EN toggling every cycle: each edge is evaluated independently;
//    there is no hysteresis.
//  - Boundary values:
//      * a=b=0             -> eq.
//      * a=b=2^WIDTH-1     -> eq.
//      * a=0, b=2^WIDTH-1  -> lt.
//      * a=2^WIDTH-1, b=0  -> gt.
//  - Reset mid-operation: outputs clear on the reset edge.
//    The first valid result appears one edge after rst falls, with EN=1.
//  - X/Z handling: none required. Inputs are assumed to be driven whenever EN=1.
// TESTING
//  1. rst=1 for 2 edges, EN=1, a=5, b=3
//     -> result=5'b00000 while rst=1;
//     -> 5'b11001 on the first edge after rst=0.
//  2. EN=1, a=0, b=0 -> result=5'b10100 one edge later (valid, eq).
//  3. EN=1, a=8, b=0 -> result=5'b11001 (valid, gt, ne).
//  4. EN=1, a=0, b=8 -> result=5'b10011 (valid, lt, ne).
//     Then a=15, b=15 -> 5'b10100.
//  5. EN=1, a=15, b=0 -> 5'b11001.
//     Next edge EN=0 -> 5'b00000.
//     Next edge EN=1, a=0, b=15 -> 5'b10011.
//  6. Random sweep of all 256 (a,b) pairs with EN=1:
//     - result must match the reference model one cycle later;
//     - gt+eq+lt must be 1 on every cycle;
//     - ne must equal gt|lt on every cycle.

Source files
------------

// File: rtl/magnitude_compare.sv
// Registered unsigned magnitude comparator producing the {valid, gt, eq, lt, ne}
// status word for the display decoder, with one cycle of latency.
module magnitude_compare #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             EN,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [4:0]       result
);

   // Flag order {gt, eq, lt, ne}; ne is derived from gt|lt so the two can never disagree.
   function automatic logic [3:0] compare_flags(input logic [WIDTH-1:0] op_a,
                                                input logic [WIDTH-1:0] op_b);
      logic gt;
      logic eq;
      logic lt;
      gt = (op_a > op_b);
      eq = (op_a == op_b);
      lt = (op_a < op_b);
      return {gt, eq, lt, gt | lt};
   endfunction

   logic [3:0] flags_p0;
   logic [3:0] flags_p1;
   logic       vld_p1;

   always_comb begin
      flags_p0 = compare_flags(a, b);
   end

   // p0 -> p1: flags are blanked together with valid so a disabled cycle reads as all zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1   <= 1'b0;
         flags_p1 <= 4'b0000;
      end else begin
         vld_p1   <= EN;
         flags_p1 <= EN ? flags_p0 : 4'b0000;
      end
   end

   assign result = {vld_p1, flags_p1};

endmodule

// File: tb/tb_magnitude_compare.sv
// Directed and exhaustive-sweep bench for magnitude_compare at WIDTH=4.
module tb_magnitude_compare;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst;
   logic             EN;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [4:0]       result;

   int n_checks;
   int n_pass;

   magnitude_compare #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .EN     (EN),
      .a      (a),
      .b      (b),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", tag, obs, exp);
   endtask

   // Drive one set of inputs, let one rising edge take them, then sample 1 time unit later.
   task automatic step(input logic r, input logic e, input logic [WIDTH-1:0] va,
                       input logic [WIDTH-1:0] vb);
      rst = r;
      EN  = e;
      a   = va;
      b   = vb;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [4:0] exp_word;
      logic [3:0] sa;
      logic [3:0] sb;
      int         idx;
      n_checks = 0;
      n_pass   = 0;
      rst = 1'b1;
      EN  = 1'b0;
      a   = '0;
      b   = '0;

      // Reset held for two edges with a compare pending, then released.
      step(1'b1, 1'b1, 4'd5, 4'd3);
      check("reset_edge1", result, 5'b00000);
      step(1'b1, 1'b1, 4'd5, 4'd3);
      check("reset_edge2", result, 5'b00000);
      step(1'b0, 1'b1, 4'd5, 4'd3);
      check("first_after_reset_5_3", result, 5'b11001);

      step(1'b0, 1'b1, 4'd0, 4'd0);
      check("eq_0_0", result, 5'b10100);
      step(1'b0, 1'b1, 4'd8, 4'd0);
      check("gt_8_0", result, 5'b11001);
      step(1'b0, 1'b1, 4'd0, 4'd8);
      check("lt_0_8", result, 5'b10011);
      step(1'b0, 1'b1, 4'd15, 4'd15);
      check("eq_15_15", result, 5'b10100);

      step(1'b0, 1'b1, 4'd15, 4'd0);
      check("gt_15_0", result, 5'b11001);
      step(1'b0, 1'b0, 4'd15, 4'd0);
      check("en_low_blank", result, 5'b00000);
      step(1'b0, 1'b1, 4'd0, 4'd15);
      check("lt_0_15", result, 5'b10011);

      // EN toggling every edge, no hysteresis.
      step(1'b0, 1'b0, 4'd7, 4'd2);
      check("toggle_off", result, 5'b00000);
      step(1'b0, 1'b1, 4'd7, 4'd2);
      check("toggle_on_gt", result, 5'b11001);
      step(1'b0, 1'b0, 4'd2, 4'd7);
      check("toggle_off2", result, 5'b00000);
      step(1'b0, 1'b1, 4'd2, 4'd7);
      check("toggle_on_lt", result, 5'b10011);

      // Reset mid-operation has priority over EN.
      step(1'b1, 1'b1, 4'd9, 4'd9);
      check("mid_reset", result, 5'b00000);
      step(1'b0, 1'b1, 4'd9, 4'd9);
      check("after_mid_reset_eq", result, 5'b10100);

      // Every (a,b) pair once, in a scrambled order (37 is odd so the map is a bijection).
      for (int i = 0; i < 256; i++) begin
         idx = (i * 37 + 11) % 256;
         sa  = idx[7:4];
         sb  = idx[3:0];
         exp_word[4] = 1'b1;
         exp_word[3] = (int'(sa) > int'(sb));
         exp_word[2] = (int'(sa) == int'(sb));
         exp_word[1] = (int'(sa) < int'(sb));
         exp_word[0] = (int'(sa) != int'(sb));
         step(1'b0, 1'b1, sa, sb);
         check($sformatf("sweep_a%0d_b%0d", sa, sb), result, exp_word);
         check("sweep_onehot",
               {2'b00, 3'(result[3] + result[2] + result[1])}, 5'd1);
         check("sweep_ne_consistent", {4'b0000, result[0]},
               {4'b0000, result[3] | result[1]});
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
